// File: rtl/pwm_compare_if.sv
// Duty-value handshake between a controller (master) and pwm_compare (slave).
// A value moves on any clock edge where duty_valid_i and duty_ready_o are both high.
interface pwm_compare_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] duty_i;
    logic             duty_valid_i;
    logic             duty_ready_o;

    modport master (
        output duty_i,
        output duty_valid_i,
        input  duty_ready_o
    );

    modport slave (
        input  duty_i,
        input  duty_valid_i,
        output duty_ready_o
    );
endinterface

// File: rtl/pwm_compare.sv
// Compare-based PWM generator driven by an external free-running period counter.
// Define PWM_COMPARE_SYNC_START_EN to hold the output off after enable until the next period boundary.
module pwm_compare #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] count_i,
    input  logic             enable_i,
    pwm_compare_if.slave     duty_if,
    output logic             pwm_o,
    output logic             period_start_o
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_PEND  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] prev_count_reg;
    logic [WIDTH-1:0] active_reg, active_next;
    logic [WIDTH-1:0] pending_reg, pending_next;
    logic             pwm_reg, pwm_next;
    logic             period_start_reg;
    logic             boundary;
    logic             ready;
    logic             accept;

    // A counter parked at zero is only one boundary, however long it stays there.
    assign boundary = (count_i == '0) && (prev_count_reg != '0);
    assign ready    = (state_reg != ST_PEND);
    assign accept   = duty_if.duty_valid_i && ready;

    assign duty_if.duty_ready_o = ready;
    assign pwm_o                = pwm_reg;
    assign period_start_o       = period_start_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_OFF;
            prev_count_reg   <= '0;
            active_reg       <= '0;
            pending_reg      <= '0;
            pwm_reg          <= 1'b0;
            period_start_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            prev_count_reg   <= count_i;
            active_reg       <= active_next;
            pending_reg      <= pending_next;
            pwm_reg          <= pwm_next;
            period_start_reg <= boundary;
        end
    end

    always_comb begin
        state_next   = state_reg;
        active_next  = active_reg;
        pending_next = pending_reg;
        pwm_next     = 1'b0;

        case (state_reg)
            ST_OFF: begin
                if (accept) begin
                    active_next = duty_if.duty_i;
                end
                if (enable_i) begin
`ifdef PWM_COMPARE_SYNC_START_EN
                    state_next = ST_ARMED;
`else
                    state_next = ST_RUN;
`endif
                end
            end

            ST_ARMED: begin
                if (accept) begin
                    active_next = duty_if.duty_i;
                end
                if (!enable_i) begin
                    state_next = ST_OFF;
                end else if (boundary) begin
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                if (!enable_i) begin
                    // Leaving for OFF: a value offered now is taken as OFF would take it.
                    if (accept) begin
                        active_next = duty_if.duty_i;
                    end
                    state_next = ST_OFF;
                end else begin
                    pwm_next = (count_i < active_reg);
                    if (accept) begin
                        pending_next = duty_if.duty_i;
                        state_next   = ST_PEND;
                    end
                end
            end

            ST_PEND: begin
                if (!enable_i) begin
                    active_next = pending_reg;
                    state_next  = ST_OFF;
                end else if (boundary) begin
                    // The new duty governs the very first step of the new period.
                    active_next = pending_reg;
                    pwm_next    = (count_i < pending_reg);
                    state_next  = ST_RUN;
                end else begin
                    pwm_next = (count_i < active_reg);
                end
            end

            default: begin
                state_next = ST_OFF;
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_compare.sv
// Directed bench for pwm_compare (WIDTH=8); expectations follow PWM_COMPARE_SYNC_START_EN when defined.
module tb_pwm_compare;

`ifdef PWM_COMPARE_SYNC_START_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] count_i;
    logic       enable_i;
    logic       pwm_o;
    logic       period_start_o;

    pwm_compare_if #(.WIDTH(8)) duty_if ();

    pwm_compare #(.WIDTH(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .count_i        (count_i),
        .enable_i       (enable_i),
        .duty_if        (duty_if.slave),
        .pwm_o          (pwm_o),
        .period_start_o (period_start_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected-behaviour bookkeeping for the directed sequence.
    int act_exp   = 0;
    int pend_exp  = 0;
    int prev_c    = 0;
    bit pend_flag = 1'b0;
    bit armed     = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Step count_i from 'from' to 'to', one value per cycle, checking every output.
    task automatic ramp(input int from, input int to);
        for (int c = from; c <= to; c++) begin
            bit bnd;
            bit exp_pwm;
            bnd = (c == 0) && (prev_c != 0);
            count_i = 8'(c);
            tick();
            if (armed) begin
                exp_pwm = 1'b0;
                if (bnd) armed = 1'b0;
            end else begin
                if (bnd && pend_flag) begin
                    act_exp   = pend_exp;
                    pend_flag = 1'b0;
                end
                exp_pwm = (c < act_exp);
            end
            check("ramp_pwm", 32'(pwm_o), 32'(exp_pwm));
            check("ramp_pstart", 32'(period_start_o), 32'(bnd));
            check("ramp_ready", 32'(duty_if.duty_ready_o), 32'(!pend_flag));
            prev_c = c;
        end
    endtask

    // Offer a new duty while running; it must go to pending, not take effect now.
    task automatic accept_at(input int c, input int d);
        bit bnd;
        bnd = (c == 0) && (prev_c != 0);
        check("acc_ready_before", 32'(duty_if.duty_ready_o), 32'd1);
        count_i              = 8'(c);
        duty_if.duty_i       = 8'(d);
        duty_if.duty_valid_i = 1'b1;
        tick();
        duty_if.duty_valid_i = 1'b0;
        check("acc_pwm", 32'(pwm_o), 32'(c < act_exp));
        check("acc_pstart", 32'(period_start_o), 32'(bnd));
        check("acc_ready_after", 32'(duty_if.duty_ready_o), 32'd0);
        pend_exp  = d;
        pend_flag = 1'b1;
        prev_c    = c;
        $display("accept duty=%0d at count=%0d", d, c);
    endtask

    initial begin
        rst_n                = 1'b0;
        count_i              = 8'd0;
        enable_i             = 1'b0;
        duty_if.duty_i       = 8'd0;
        duty_if.duty_valid_i = 1'b0;
        #1;
        check("rst_pwm_async", 32'(pwm_o), 32'd0);
        check("rst_ready_async", 32'(duty_if.duty_ready_o), 32'd1);
        repeat (3) tick();
        check("rst_pwm", 32'(pwm_o), 32'd0);
        check("rst_pstart", 32'(period_start_o), 32'd0);
        check("rst_ready", 32'(duty_if.duty_ready_o), 32'd1);
        rst_n = 1'b1;

        // Duty 64 loaded while off, then enabled just before a wrap.
        duty_if.duty_i       = 8'd64;
        duty_if.duty_valid_i = 1'b1;
        tick();
        duty_if.duty_valid_i = 1'b0;
        check("off_load_pwm", 32'(pwm_o), 32'd0);
        check("off_load_ready", 32'(duty_if.duty_ready_o), 32'd1);
        act_exp = 64;
        enable_i = 1'b1;
        count_i  = 8'd255;
        tick();
        check("enable_pwm", 32'(pwm_o), 32'd0);
        check("enable_pstart", 32'(period_start_o), 32'd0);
        armed  = SYNC;
        prev_c = 255;
        $display("scenario: duty 64 ramp, two periods");
        ramp(0, 255);
        ramp(0, 255);

        $display("scenario: duty 192 requested mid-period");
        ramp(0, 99);
        accept_at(100, 192);
        ramp(101, 255);
        ramp(0, 255);

        $display("scenario: duty 32 requested on the boundary cycle");
        accept_at(0, 32);
        ramp(1, 255);
        ramp(0, 255);

        $display("scenario: duty extremes 0 and 255");
        accept_at(200, 0);
        ramp(201, 255);
        ramp(0, 255);
        accept_at(200, 255);
        ramp(201, 255);
        ramp(0, 255);

        $display("scenario: disable, reload 64, enable at count 50");
        enable_i = 1'b0;
        count_i  = 8'd20;
        tick();
        check("dis_pwm", 32'(pwm_o), 32'd0);
        check("dis_ready", 32'(duty_if.duty_ready_o), 32'd1);
        check("dis_pstart", 32'(period_start_o), 32'd0);
        count_i              = 8'd30;
        duty_if.duty_i       = 8'd64;
        duty_if.duty_valid_i = 1'b1;
        tick();
        duty_if.duty_valid_i = 1'b0;
        check("off_reload_pwm", 32'(pwm_o), 32'd0);
        act_exp  = 64;
        enable_i = 1'b1;
        count_i  = 8'd50;
        tick();
        check("en50_pwm", 32'(pwm_o), 32'd0);
        armed  = SYNC;
        prev_c = 50;
        ramp(51, 255);
        ramp(0, 255);

        $display("scenario: disable while pending duty 10");
        accept_at(100, 10);
        ramp(101, 110);
        enable_i = 1'b0;
        count_i  = 8'd111;
        tick();
        check("pend_dis_pwm", 32'(pwm_o), 32'd0);
        check("pend_dis_ready", 32'(duty_if.duty_ready_o), 32'd1);
        act_exp   = pend_exp;
        pend_flag = 1'b0;
        enable_i  = 1'b1;
        count_i   = 8'd5;
        tick();
        check("re_en_pwm", 32'(pwm_o), 32'd0);
        armed  = SYNC;
        prev_c = 5;
        ramp(6, 255);
        ramp(0, 99);

        $display("scenario: reset in PEND at count 120");
        accept_at(100, 200);
        ramp(101, 255);
        ramp(0, 109);
        accept_at(110, 50);
        ramp(111, 120);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_pend_pwm", 32'(pwm_o), 32'd0);
        check("rst_pend_ready", 32'(duty_if.duty_ready_o), 32'd1);
        check("rst_pend_pstart", 32'(period_start_o), 32'd0);
        repeat (2) tick();
        rst_n     = 1'b1;
        act_exp   = 0;
        pend_flag = 1'b0;
        count_i   = 8'd121;
        tick();
        check("post_rst_pwm", 32'(pwm_o), 32'd0);
        check("post_rst_ready", 32'(duty_if.duty_ready_o), 32'd1);
        armed  = SYNC;
        prev_c = 121;
        ramp(122, 255);
        ramp(0, 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_compare.md
PWM_COMPARE -- requirements
Module: pwm_compare

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the width of the count and duty values.
REQ-002 SHALL have port clk  input  1  sole clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port count_i  input  WIDTH  period count from the upstream counter; free-running and wrapping; may hold for many cycles between steps.
REQ-005 SHALL have port enable_i  input  1  level; 1 = generate PWM, 0 = output held low.
REQ-006 SHALL have port duty_i  input  WIDTH  requested duty value (high steps per period).
REQ-007 SHALL have port duty_valid_i  input  1  duty_i is valid.
REQ-008 SHALL have port duty_ready_o  output  1  block can accept a new duty value.
REQ-009 SHALL have port pwm_o  output  1  registered PWM output.
REQ-010 SHALL have port period_start_o  output  1  one-cycle pulse on each detected period boundary.

Function
REQ-011 SHALL register count_i every cycle as prev_count; boundary = (count_i == 0) and (prev_count != 0); a count held at 0 SHALL NOT create further boundaries.
REQ-012 SHALL drive period_start_o high for exactly the cycle after a boundary is seen, in every state.
REQ-013 SHALL hold an active duty register (used for comparison) and a pending duty register.
REQ-014 SHALL accept a duty value only on a cycle where duty_valid_i and duty_ready_o are both 1.
REQ-015 SHALL implement states OFF, ARMED, RUN, PEND.
REQ-016 OFF: pwm_o=0; duty_ready_o=1; an accepted duty value SHALL be written to active duty on the next edge; enable_i=1 -> ARMED.
REQ-017 ARMED: pwm_o=0; duty_ready_o=1; acceptance as in OFF; boundary -> RUN; enable_i=0 -> OFF.
REQ-018 RUN: pwm_o <= (count_i < active duty), registered, one cycle of latency; duty_ready_o=1; acceptance writes pending duty -> PEND.
REQ-019 PEND: duty_ready_o=0; comparison continues with the old active duty; on a boundary, pending is copied to active, and the comparison in that same cycle SHALL use the new value -> RUN.
REQ-020 An acceptance in RUN on the same cycle as a boundary SHALL go to PEND and SHALL apply at the following boundary, not the current one.
REQ-021 enable_i=0 in RUN or PEND SHALL force pwm_o=0 on the next edge and enter OFF; a value held in PEND SHALL be copied to active on that same edge.
REQ-022 Duty 0 SHALL give pwm_o constantly 0; duty 2^WIDTH-1 SHALL give pwm_o 1 for every count except 2^WIDTH-1.
REQ-023 The comparison SHALL be unsigned with WIDTH bits and no widening; wrap of count_i needs no special handling beyond REQ-011.

Reset
REQ-024 While rst_n=0, the block SHALL hold:
- state = OFF
- active and pending duty = 0
- prev_count = 0
- pwm_o = 0
- period_start_o = 0
- duty_ready_o = 1
REQ-025 Reset asserted in any state, mid-period, SHALL take effect immediately and asynchronously; a pending duty value SHALL be discarded.

Configuration
REQ-026 Macro PWM_COMPARE_SYNC_START_EN: when defined, enable_i rising in OFF SHALL go to ARMED and wait for a boundary (REQ-017).
REQ-027 When PWM_COMPARE_SYNC_START_EN is not defined, ARMED SHALL NOT be reachable: OFF with enable_i=1 SHALL go directly to RUN and compare from the next cycle.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- WIDTH=8, duty 64 accepted in OFF, enable=1, count ramps 0..255 one step per cycle -> pwm_o high for 64 consecutive cycles per period, 1 cycle after count; period_start_o pulses once per wrap.
- In RUN with duty 64, accept duty 192 at count=100 -> duty_ready_o=0 until wrap; 64 used for rest of period; 192 from count=0; ready=1 after.
- Accept duty in RUN on the exact boundary cycle -> value applies one full period later.
- Duty 0 -> pwm_o never high; duty 255 -> pwm_o low only at count 255.
- With SYNC_START_EN, enable at count=50 -> pwm_o stays 0 until count wraps to 0; without the macro -> pwm_o follows compare from the next cycle.
- rst_n pulled low in PEND at count=120 -> pwm_o=0 and duty_ready_o=1 at once; the old pending value is never applied.
